// File: rtl/am_insert.sv
// am_insert: inserts the per-lane alignment marker (AM) into a 66-bit block stream,
//   one AM every AM_PERIOD output blocks, carrying the BIP of the blocks since the last AM.
// Latency: 1 clock from input transfer to out_data/out_valid. Backpressure: in_ready low
//   during the AM slot and while en is low; downstream is always ready.
// Ports: clk/reset (async active-low), en (sync clear), in_data/in_valid/in_ready (upstream),
//   out_data/out_valid/am_flag/am_counter_out (registered lane stream + period position).
module am_insert #(
  parameter int LANE      = 0,
  parameter int AM_PERIOD = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [65:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [65:0] out_data,
  output logic        out_valid,
  output logic        am_flag,
  output logic [13:0] am_counter_out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Marker bytes packed as {M2, M1, M0}.
  function automatic logic [23:0] lane_marker(input int lane);
    case (lane)
      1:       return 24'hE6C4F0;
      2:       return 24'h9B65C5;
      3:       return 24'h3D79A2;
      default: return 24'h477690;
    endcase
  endfunction

  // Column parity over the eight payload bytes, with the sync header folded into bits 3/4.
  function automatic logic [7:0] blk_par(input logic [65:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      p = p ^ b[2+8*k +: 8];
    end
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  localparam logic [23:0] AM_M     = lane_marker(LANE);
  localparam logic [13:0] CNT_LAST = 14'(AM_PERIOD - 1);

  state_t      r_state;
  logic [13:0] r_cnt;
  logic [7:0]  r_bip;
  logic [65:0] r_out_data;
  logic        r_out_valid;
  logic        r_am_flag;
  logic [13:0] r_am_cnt;

  logic        w_in_ready;
  logic        w_xfer;
  logic [65:0] w_am_blk;

  // en is included so an input presented in the cycle en drops is never handshaken.
  assign w_in_ready = en && (r_state == S_RUN) && (r_cnt != 14'd0);
  assign w_xfer     = in_valid && w_in_ready;

  // Bytes 0..7 = M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3, sync header 01.
  assign w_am_blk = {~r_bip, ~AM_M, r_bip, AM_M, 2'b01};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 14'd0;
      r_bip       <= 8'h00;
      r_out_data  <= 66'd0;
      r_out_valid <= 1'b0;
      r_am_flag   <= 1'b0;
      r_am_cnt    <= 14'd0;
    end else if (!en) begin
      r_state     <= S_IDLE;
      r_cnt       <= 14'd0;
      r_bip       <= 8'h00;
      r_out_valid <= 1'b0;
      r_am_flag   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_RUN;
          r_cnt       <= 14'd0;
          r_bip       <= 8'h00;
          r_out_valid <= 1'b0;
          r_am_flag   <= 1'b0;
        end
        S_RUN: begin
          if (r_cnt == 14'd0) begin
            // AM slot is taken unconditionally; the accumulator restarts from the AM's own parity.
            r_out_data  <= w_am_blk;
            r_out_valid <= 1'b1;
            r_am_flag   <= 1'b1;
            r_am_cnt    <= 14'd0;
            r_cnt       <= 14'd1;
            r_bip       <= blk_par(w_am_blk);
          end else if (w_xfer) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
            r_am_flag   <= 1'b0;
            r_am_cnt    <= r_cnt;
            r_cnt       <= (r_cnt == CNT_LAST) ? 14'd0 : r_cnt + 14'd1;
            r_bip       <= r_bip ^ blk_par(in_data);
          end else begin
            // Bubble: out_data/am_flag/am_counter_out keep describing the last emitted block.
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = w_in_ready;
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign am_flag        = r_am_flag;
  assign am_counter_out = r_am_cnt;

endmodule

// File: tb/tb_am_insert.sv
// tb_am_insert: self-checking bench for am_insert (lane 0 and lane 3 instances).
// Latency: n/a. Backpressure: the bench honours in_ready and predicts it from its own model.
// Ports: none.
module tb_am_insert;

  localparam int PERIOD = 16384;

  logic        clk;
  logic        reset, en, in_valid, in_ready, out_valid, am_flag;
  logic [65:0] in_data, out_data;
  logic [13:0] am_counter_out;

  logic        reset3, en3, in_valid3, in_ready3, out_valid3, am_flag3;
  logic [65:0] in_data3, out_data3;
  logic [13:0] am_counter_out3;

  int n_chk;
  int n_fail;

  am_insert #(.LANE(0), .AM_PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .am_flag(am_flag),
    .am_counter_out(am_counter_out)
  );

  am_insert #(.LANE(3), .AM_PERIOD(PERIOD)) dut3 (
    .clk(clk), .reset(reset3), .en(en3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .am_flag(am_flag3),
    .am_counter_out(am_counter_out3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference parity: bit o is the XOR of bit o of every payload byte, sync bits fold into 3 and 4.
  function automatic logic [7:0] ref_par(input logic [65:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 8; k++) begin
        p[o] = p[o] ^ b[2 + 8*k + o];
      end
    end
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  function automatic logic [65:0] ref_am(input int lane, input logic [7:0] bip);
    logic [7:0]  m0, m1, m2;
    logic [65:0] b;
    case (lane)
      1:       begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; end
      2:       begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; end
      3:       begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; end
      default: begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; end
    endcase
    b[1:0]   = 2'b01;
    b[9:2]   = m0;
    b[17:10] = m1;
    b[25:18] = m2;
    b[33:26] = bip;
    b[41:34] = ~m0;
    b[49:42] = ~m1;
    b[57:50] = ~m2;
    b[65:58] = ~bip;
    return b;
  endfunction

  task automatic do_reset();
    reset    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = 66'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, 2'b10};
    #3;
    n_chk++; if (out_data !== 66'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (am_flag !== 1'b0) begin n_fail++; $display("FAIL reset_am_flag: got %b expected 0", am_flag); end
    n_chk++; if (am_counter_out !== 14'd0) begin n_fail++; $display("FAIL reset_am_counter: got %0d expected 0", am_counter_out); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
    end
  endtask

  task automatic test_first_am();
    logic [65:0] exp_am;
    exp_am   = {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01};
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, 2'b10};
    @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL entry_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL am_slot_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    n_chk++; if (out_data !== exp_am) begin n_fail++; $display("FAIL first_am_data: got %h expected %h", out_data, exp_am); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_am_valid: got %b expected 1", out_valid); end
    n_chk++; if (am_flag !== 1'b1) begin n_fail++; $display("FAIL first_am_flag: got %b expected 1", am_flag); end
    n_chk++; if (am_counter_out !== 14'd0) begin n_fail++; $display("FAIL first_am_counter: got %0d expected 0", am_counter_out); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_am_in_ready: got %b expected 1", in_ready); end
    en = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Three AMs with a 10-cycle stall at counter 500 and random bubbles in the last period.
  // Payload {~seq, seq} contributes zero parity, so each data block adds exactly 0x10 to the BIP.
  task automatic test_stream();
    int          pos, ams, gap_left, cyc, obs_am, obs_since;
    bit          gap_done;
    logic [7:0]  bip;
    logic [31:0] seq;
    logic        exp_vld, exp_am, exp_rdy;
    logic [65:0] exp_dat;
    logic [13:0] exp_cnt;
    do_reset();
    en = 1'b1;
    @(posedge clk);
    #1;
    pos = 0; ams = 0; gap_left = 0; cyc = 0; obs_am = 0; obs_since = 0;
    gap_done = 1'b0; bip = 8'h00; seq = 32'd0;
    exp_dat = 66'd0; exp_cnt = 14'd0; exp_am = 1'b0;
    while (ams < 3 && cyc < 40000) begin
      cyc++;
      if (!gap_done && ams == 1 && pos == 500) begin
        gap_left = 10;
        gap_done = 1'b1;
      end
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else if (ams >= 2) begin
        in_valid = ($urandom_range(0, 31) != 0);
      end else begin
        in_valid = 1'b1;
      end
      in_data = in_valid ? {~seq, seq, 2'b10} : {$urandom, $urandom, 2'b11};
      exp_rdy = (pos != 0);
      n_chk++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL stream_in_ready: got %b expected %b at pos %0d", in_ready, exp_rdy, pos); end
      if (pos == 0) begin
        exp_vld = 1'b1; exp_am = 1'b1; exp_cnt = 14'd0;
        exp_dat = ref_am(0, bip);
        bip = ref_par(exp_dat);
        pos = 1;
        ams++;
      end else if (in_valid) begin
        exp_vld = 1'b1; exp_am = 1'b0; exp_cnt = 14'(pos);
        exp_dat = in_data;
        bip = bip ^ ref_par(in_data);
        pos = (pos + 1) % PERIOD;
        seq++;
      end else begin
        exp_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL stream_out_valid: got %b expected %b cycle %0d", out_valid, exp_vld, cyc); end
      if (exp_vld) begin
        n_chk++; if (out_data !== exp_dat) begin n_fail++; $display("FAIL stream_out_data: got %h expected %h cycle %0d", out_data, exp_dat, cyc); end
        n_chk++; if (am_flag !== exp_am) begin n_fail++; $display("FAIL stream_am_flag: got %b expected %b cycle %0d", am_flag, exp_am, cyc); end
        n_chk++; if (am_counter_out !== exp_cnt) begin n_fail++; $display("FAIL stream_counter: got %0d expected %0d cycle %0d", am_counter_out, exp_cnt, cyc); end
      end
      if (out_valid === 1'b1 && am_flag === 1'b0) obs_since++;
      if (out_valid === 1'b1 && am_flag === 1'b1) begin
        if (obs_am > 0) begin
          n_chk++; if (obs_since != 16383) begin n_fail++; $display("FAIL am_spacing: got %0d data blocks expected 16383", obs_since); end
          n_chk++; if (out_data[33:26] !== 8'h18) begin n_fail++; $display("FAIL am_bip3: got %h expected 18", out_data[33:26]); end
          n_chk++; if (out_data[65:58] !== 8'hE7) begin n_fail++; $display("FAIL am_bip7: got %h expected e7", out_data[65:58]); end
        end
        obs_am++;
        obs_since = 0;
      end
    end
    n_chk++; if (ams < 3 || obs_am != 3) begin n_fail++; $display("FAIL stream_timeout: got %0d AMs expected 3", obs_am); end
    en = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic [65:0] d, exp_am;
    bit          seen;
    do_reset();
    en = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom, 2'b10};
      in_data = d;
      @(posedge clk);
      #1;
      if (i == 0) begin
        exp_am = ref_am(0, 8'h00);
        n_chk++; if (out_data !== exp_am) begin n_fail++; $display("FAIL en_first_am: got %h expected %h", out_data, exp_am); end
      end else begin
        n_chk++; if (out_data !== d || am_counter_out !== 14'(i)) begin n_fail++; $display("FAIL en_data: got %h/%0d expected %h/%0d", out_data, am_counter_out, d, i); end
      end
    end
    en = 1'b0;
    in_data = {$urandom, $urandom, 2'b10};
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_in_ready_comb: got %b expected 0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0 || am_flag !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL en_low_outputs: got valid %b flag %b ready %b expected 0 0 0", out_valid, am_flag, in_ready);
      end
    end
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    exp_am = ref_am(0, 8'h00);
    n_chk++; if (!seen) begin n_fail++; $display("FAIL reenable_timeout: got no block expected AM"); end
    n_chk++; if (out_data !== exp_am || am_flag !== 1'b1 || am_counter_out !== 14'd0) begin
      n_fail++; $display("FAIL reenable_am: got %h flag %b cnt %0d expected %h flag 1 cnt 0", out_data, am_flag, am_counter_out, exp_am);
    end
    en = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_lane3();
    logic [65:0] d, exp_am;
    exp_am    = {8'hFF, 8'hC2, 8'h86, 8'h5D, 8'h00, 8'h3D, 8'h79, 8'hA2, 2'b01};
    reset3    = 1'b0;
    en3       = 1'b0;
    in_valid3 = 1'b0;
    in_data3  = 66'd0;
    @(posedge clk);
    #1;
    reset3    = 1'b1;
    en3       = 1'b1;
    in_valid3 = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_chk++; if (out_data3 !== exp_am || am_flag3 !== 1'b1) begin n_fail++; $display("FAIL lane3_am: got %h flag %b expected %h flag 1", out_data3, am_flag3, exp_am); end
    for (int i = 1; i <= 200; i++) begin
      d = {$urandom, $urandom, 2'b10};
      in_data3 = d;
      @(posedge clk);
      #1;
      n_chk++; if (out_data3 !== d || out_valid3 !== 1'b1 || am_counter_out3 !== 14'(i)) begin
        n_fail++; $display("FAIL lane3_data: got %h/%b/%0d expected %h/1/%0d", out_data3, out_valid3, am_counter_out3, d, i);
      end
    end
    @(negedge clk);
    #2;
    reset3 = 1'b0;
    #1;
    n_chk++; if (out_data3 !== 66'd0 || out_valid3 !== 1'b0 || am_flag3 !== 1'b0 || am_counter_out3 !== 14'd0 || in_ready3 !== 1'b0) begin
      n_fail++; $display("FAIL lane3_async_reset: got %h %b %b %0d %b expected all zero", out_data3, out_valid3, am_flag3, am_counter_out3, in_ready3);
    end
    en3 = 1'b0;
    in_valid3 = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset3    = 1'b0;
    en3       = 1'b0;
    in_valid3 = 1'b0;
    in_data3  = 66'd0;
    test_reset();
    test_first_am();
    test_stream();
    test_en_toggle();
    test_lane3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/am_insert.md
AM_INSERT -- requirements
Module: am_insert

Interface
REQ-001 SHALL provide parameter LANE, default 0, selecting the PCS lane (0..3) whose alignment marker (AM) is inserted.
REQ-002 SHALL provide parameter AM_PERIOD, default 16384, giving the number of output blocks per period, AM included; the counter is 14 bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, transmit enable; low clears the block synchronously.
REQ-006 SHALL have port in_data, input, 66, scrambled block: [1:0] sync header, byte k at [9+8k:2+8k].
REQ-007 SHALL have port in_valid, input, 1, in_data valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-009 SHALL have port out_data, output, 66, lane block stream, same packing as in_data.
REQ-010 SHALL have port out_valid, output, 1, out_data valid; downstream is always ready.
REQ-011 SHALL have port am_flag, output, 1, high when out_data is an AM.
REQ-012 SHALL have port am_counter_out, output, 14, period position of the current out_data (0 = AM).

Function
REQ-013 SHALL implement two states: IDLE and RUN.
REQ-014 IDLE SHALL go to RUN on a clock with en=1; any state SHALL go to IDLE on a clock with en=0.
REQ-015 Entry to RUN SHALL set the slot counter to 0 and the BIP accumulator to 0x00.
REQ-016 in_ready SHALL be 1 only in RUN with counter != 0; a transfer occurs when in_valid && in_ready.
REQ-017 AM slot (RUN, counter=0): at the clock edge, out_data <= AM, out_valid <= 1, am_flag <= 1, counter <= 1, regardless of in_valid.
REQ-018 Data slot (RUN, counter != 0), on transfer: out_data <= in_data unmodified, out_valid <= 1, am_flag <= 0, counter increments; 16383 SHALL wrap to 0.
REQ-019 Data slot without transfer: out_valid <= 0, counter and BIP held, out_data held.
REQ-020 Latency SHALL be exactly 1 clock from transfer to out_data/out_valid; block order SHALL be preserved.
REQ-021 am_counter_out SHALL be registered with out_data and equal the counter value of the slot that produced it.
REQ-022 AM format: sync 2'b01; M0,M1,M2 at bytes 0-2; BIP3 at byte 3; M4,M5,M6 = ~M0,~M1,~M2 at bytes 4-6; BIP7 = ~BIP3 at byte 7.
REQ-023 M0/M1/M2 SHALL be: LANE0 90/76/47; LANE1 F0/C4/E6; LANE2 C5/65/9B; LANE3 A2/79/3D.
REQ-024 Block parity f(b) SHALL be 8 bits:
- bit o = XOR over k=0..7 of b[2+8k+o]
- additionally bit 3 ^= b[0] and bit 4 ^= b[1]
REQ-025 The BIP accumulator SHALL XOR in f(out block) for every block output.
REQ-026 At an AM slot, BIP3 SHALL equal the accumulator, then the accumulator SHALL load f(emitted AM), i.e. 0x08 for any lane.
REQ-027 en=0 in any state: next edge out_valid=0, am_flag=0, in_ready=0, counter=0, accumulator=0; an in-flight input is not transferred.
REQ-028 Re-enabling SHALL restart with an AM whose BIP3=0x00.

Reset
REQ-029 reset=0 SHALL asynchronously force:
- state IDLE, counter 0, accumulator 0x00
- out_data 0, out_valid 0, am_flag 0, am_counter_out 0, in_ready 0
REQ-030 After reset release, the block SHALL stay in IDLE until en=1 is sampled.

Verification
REQ-031 LANE=0, reset then en=1, in_valid=1 constant -> first out block: sync 01, bytes 90 76 47 00 6F 89 B8 FF; am_flag=1, am_counter_out=0; in_ready=0 during that slot.
REQ-032 Continuous valid input, incrementing payload -> AMs at output indices 0, 16384 and 32768, with exactly 16383 in-order unmodified data blocks between AMs.
REQ-033 BIP check: all data blocks sync 2'b10, payload 0 -> second AM BIP3=0x18, BIP7=0xE7; third AM BIP3=0x18.
REQ-034 in_valid low for 10 cycles at counter 500 -> out_valid=0 for those cycles, counter holds at 500, next AM still follows exactly 16383 data blocks.
REQ-035 en dropped at counter 100, re-raised 5 cycles later -> out_valid=0 and in_ready=0 while low; first block after re-raise is an AM with BIP3=0x00, am_counter_out=0.
REQ-036 LANE=3 -> AM bytes A2 79 3D BIP3 5D 86 C2 ~BIP3; reset asserted mid-period -> all outputs 0 immediately, without waiting for a clock edge.
